// File: rtl/beta_fetch_redirect_ctrl.sv
// Fetch sequencer: owns the fetch PC, drives a single-outstanding req/gnt/rvalid bus,
// buffers one instruction for decode and applies execute-stage redirects/exceptions.
module beta_fetch_redirect_ctrl #(
    parameter int unsigned           DATAWIDTH = 32,
    parameter logic [DATAWIDTH-1:0]  BOOT_ADDR = 32'h0000_0000,
    parameter logic [DATAWIDTH-1:0]  TRAP_ADDR = 32'h0000_0100
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 exe_valid_i,
    input  logic [DATAWIDTH-1:0] exe_pc_i,
    input  logic [1:0]           bju_en_i,
    input  logic                 bju_branch_taken_i,
    input  logic [DATAWIDTH-1:0] bju_next_pc_i,
    input  logic                 bju_misalig_pc_i,
    output logic                 fetch_req_o,
    output logic [DATAWIDTH-1:0] fetch_addr_o,
    input  logic                 fetch_gnt_i,
    input  logic                 fetch_rvalid_i,
    input  logic [DATAWIDTH-1:0] fetch_rdata_i,
    output logic                 if_valid_o,
    output logic [DATAWIDTH-1:0] if_instr_o,
    output logic [DATAWIDTH-1:0] if_pc_o,
    input  logic                 if_ready_i,
    output logic                 flush_o,
    output logic                 exc_valid_o,
    output logic [DATAWIDTH-1:0] exc_tval_o
);

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_WAIT    = 2'd2,
        S_DISCARD = 2'd3
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [DATAWIDTH-1:0] pc_q;
    logic [DATAWIDTH-1:0] req_pc_q;
    logic [DATAWIDTH-1:0] target;
    logic                 redir;
    logic                 exc;
    logic                 accept;

    // Redirect decode from the execute-stage branch/jump unit
    always_comb begin
        redir  = exe_valid_i & (((bju_en_i == 2'b01) & bju_branch_taken_i) | bju_en_i[1]);
        exc    = redir & bju_misalig_pc_i;
        target = exc ? TRAP_ADDR : bju_next_pc_i;
    end

    // A response is only kept when it answers the live request and no redirect squashes it
    assign accept = (state_q == S_WAIT) & fetch_rvalid_i & ~redir;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    state_d = S_REQ;
            S_REQ:     if (fetch_req_o & fetch_gnt_i) state_d = S_WAIT;
            S_WAIT: begin
                if (fetch_rvalid_i) begin
                    state_d = S_REQ;
                end else if (redir) begin
                    state_d = S_DISCARD;
                end
            end
            S_DISCARD: if (fetch_rvalid_i) state_d = S_REQ;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        fetch_req_o  = 1'b0;
        fetch_addr_o = pc_q;
        flush_o      = redir;
        if (state_q == S_REQ) begin
            fetch_req_o = (~if_valid_o | if_ready_i) & ~redir;
        end
    end

    // Fetch PC and address of the outstanding request
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q     <= BOOT_ADDR;
            req_pc_q <= '0;
        end else begin
            if ((state_q != S_IDLE) && redir) begin
                pc_q <= target;
            end else if (accept) begin
                pc_q <= req_pc_q + DATAWIDTH'(4);
            end
            if (fetch_req_o && fetch_gnt_i) begin
                req_pc_q <= pc_q;
            end
        end
    end

    // One-entry instruction buffer; a fill wins over a same-cycle consume
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            if_valid_o <= 1'b0;
            if_instr_o <= '0;
            if_pc_o    <= '0;
        end else if (accept) begin
            if_valid_o <= 1'b1;
            if_instr_o <= fetch_rdata_i;
            if_pc_o    <= req_pc_q;
        end else if (redir || (if_ready_i && if_valid_o)) begin
            if_valid_o <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            exc_valid_o <= 1'b0;
            exc_tval_o  <= '0;
        end else begin
            exc_valid_o <= exc;
            if (exc) begin
                exc_tval_o <= exe_pc_i;
            end
        end
    end

endmodule

// File: tb/tb_beta_fetch_redirect_ctrl.sv
// Directed bench for beta_fetch_redirect_ctrl: sequential fetch, redirects,
// misaligned-target exception, decode back-pressure, PC wrap and reset mid-flight.
module tb_beta_fetch_redirect_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        exe_valid_i;
    logic [31:0] exe_pc_i;
    logic [1:0]  bju_en_i;
    logic        bju_branch_taken_i;
    logic [31:0] bju_next_pc_i;
    logic        bju_misalig_pc_i;
    logic        fetch_req_o;
    logic [31:0] fetch_addr_o;
    logic        fetch_gnt_i;
    logic        fetch_rvalid_i;
    logic [31:0] fetch_rdata_i;
    logic        if_valid_o;
    logic [31:0] if_instr_o;
    logic [31:0] if_pc_o;
    logic        if_ready_i;
    logic        flush_o;
    logic        exc_valid_o;
    logic [31:0] exc_tval_o;

    int total = 0;
    int bad   = 0;

    beta_fetch_redirect_ctrl dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .exe_valid_i        (exe_valid_i),
        .exe_pc_i           (exe_pc_i),
        .bju_en_i           (bju_en_i),
        .bju_branch_taken_i (bju_branch_taken_i),
        .bju_next_pc_i      (bju_next_pc_i),
        .bju_misalig_pc_i   (bju_misalig_pc_i),
        .fetch_req_o        (fetch_req_o),
        .fetch_addr_o       (fetch_addr_o),
        .fetch_gnt_i        (fetch_gnt_i),
        .fetch_rvalid_i     (fetch_rvalid_i),
        .fetch_rdata_i      (fetch_rdata_i),
        .if_valid_o         (if_valid_o),
        .if_instr_o         (if_instr_o),
        .if_pc_o            (if_pc_o),
        .if_ready_i         (if_ready_i),
        .flush_o            (flush_o),
        .exc_valid_o        (exc_valid_o),
        .exc_tval_o         (exc_tval_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic bju(input logic v, input logic [1:0] en, input logic tk,
                       input logic [31:0] tgt, input logic mis, input logic [31:0] pc);
        exe_valid_i        = v;
        bju_en_i           = en;
        bju_branch_taken_i = tk;
        bju_next_pc_i      = tgt;
        bju_misalig_pc_i   = mis;
        exe_pc_i           = pc;
    endtask

    initial begin
        rst_i = 1'b1;
        bju(1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
        fetch_gnt_i = 1'b1; fetch_rvalid_i = 1'b0; fetch_rdata_i = 32'h0; if_ready_i = 1'b1;
        tick(); tick();
        #1;
        chk("rst_req", 32'(fetch_req_o), 32'h0);
        chk("rst_ifv", 32'(if_valid_o), 32'h0);
        chk("rst_exc", 32'(exc_valid_o), 32'h0);
        chk("rst_tval", exc_tval_o, 32'h0);
        chk("rst_instr", if_instr_o, 32'h0);
        chk("rst_ifpc", if_pc_o, 32'h0);

        // Sequential fetch with gnt always high and rvalid one cycle after gnt
        rst_i = 1'b0;
        tick();                                   // REQ
        #1;
        chk("seq_req0", 32'(fetch_req_o), 32'h1);
        chk("seq_addr0", fetch_addr_o, 32'h0);
        tick();                                   // WAIT
        fetch_rvalid_i = 1'b1; fetch_rdata_i = 32'h1111_0000; #1;
        chk("seq_wait_req", 32'(fetch_req_o), 32'h0);
        tick();                                   // REQ, buffer filled
        fetch_rvalid_i = 1'b0; #1;
        chk("seq_ifv0", 32'(if_valid_o), 32'h1);
        chk("seq_ifpc0", if_pc_o, 32'h0);
        chk("seq_instr0", if_instr_o, 32'h1111_0000);
        chk("seq_addr4", fetch_addr_o, 32'h4);
        chk("seq_req4", 32'(fetch_req_o), 32'h1);
        tick();                                   // WAIT
        fetch_rvalid_i = 1'b1; fetch_rdata_i = 32'h2222_0004; #1;
        chk("seq_consumed", 32'(if_valid_o), 32'h0);
        tick();                                   // REQ
        fetch_rvalid_i = 1'b0; #1;
        chk("seq_ifpc4", if_pc_o, 32'h4);
        chk("seq_addr8", fetch_addr_o, 32'h8);
        chk("seq_req8", 32'(fetch_req_o), 32'h1);
        tick();                                   // WAIT

        // Taken branch with rvalid in the same cycle
        bju(1'b1, 2'b01, 1'b1, 32'h0000_0200, 1'b0, 32'h10);
        fetch_rvalid_i = 1'b1; fetch_rdata_i = 32'hDEAD_0008; #1;
        chk("br_flush", 32'(flush_o), 32'h1);
        chk("br_req", 32'(fetch_req_o), 32'h0);
        tick();
        bju(1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
        fetch_rvalid_i = 1'b0; #1;
        chk("br_ifv", 32'(if_valid_o), 32'h0);
        chk("br_req_next", 32'(fetch_req_o), 32'h1);
        chk("br_addr", fetch_addr_o, 32'h0000_0200);
        chk("br_flush_off", 32'(flush_o), 32'h0);
        tick();                                   // WAIT

        // JAL in WAIT, response three cycles later must be discarded
        bju(1'b1, 2'b10, 1'b0, 32'h0000_0080, 1'b0, 32'h20); #1;
        chk("jal_flush", 32'(flush_o), 32'h1);
        tick();                                   // DISCARD
        bju(1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0); #1;
        chk("disc_req1", 32'(fetch_req_o), 32'h0);
        tick(); #1;
        chk("disc_req2", 32'(fetch_req_o), 32'h0);
        tick();
        fetch_rvalid_i = 1'b1; fetch_rdata_i = 32'h0BAD_0200; #1;
        chk("disc_req3", 32'(fetch_req_o), 32'h0);
        tick();                                   // REQ
        fetch_rvalid_i = 1'b0; #1;
        chk("disc_ifv", 32'(if_valid_o), 32'h0);
        chk("disc_req", 32'(fetch_req_o), 32'h1);
        chk("disc_addr", fetch_addr_o, 32'h0000_0080);
        tick();                                   // WAIT

        // Misaligned JALR raises a one-cycle exception and refetches from trap vector
        bju(1'b1, 2'b11, 1'b0, 32'h0000_0083, 1'b1, 32'h0000_0044); #1;
        chk("exc_flush", 32'(flush_o), 32'h1);
        chk("exc_pre", 32'(exc_valid_o), 32'h0);
        tick();                                   // DISCARD
        bju(1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
        fetch_rvalid_i = 1'b1; fetch_rdata_i = 32'h0BAD_0080; #1;
        chk("exc_valid", 32'(exc_valid_o), 32'h1);
        chk("exc_tval", exc_tval_o, 32'h0000_0044);
        tick();                                   // REQ
        fetch_rvalid_i = 1'b0; #1;
        chk("exc_pulse", 32'(exc_valid_o), 32'h0);
        chk("exc_tval_hold", exc_tval_o, 32'h0000_0044);
        chk("trap_req", 32'(fetch_req_o), 32'h1);
        chk("trap_addr", fetch_addr_o, 32'h0000_0100);
        tick();                                   // WAIT

        // Not-taken branch with misalign flag set has no effect
        bju(1'b1, 2'b01, 1'b0, 32'h0000_0300, 1'b1, 32'h0000_0050);
        fetch_rvalid_i = 1'b1; fetch_rdata_i = 32'h3333_0100; #1;
        chk("nt_flush", 32'(flush_o), 32'h0);
        tick();                                   // REQ, buffer full
        bju(1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
        fetch_rvalid_i = 1'b0; if_ready_i = 1'b0; #1;
        chk("nt_exc", 32'(exc_valid_o), 32'h0);
        chk("nt_ifpc", if_pc_o, 32'h0000_0100);
        chk("nt_instr", if_instr_o, 32'h3333_0100);
        for (int i = 0; i < 5; i++) begin
            chk("stall_ifv", 32'(if_valid_o), 32'h1);
            chk("stall_req", 32'(fetch_req_o), 32'h0);
            tick();
        end
        if_ready_i = 1'b1; #1;
        chk("rel_req", 32'(fetch_req_o), 32'h1);
        chk("rel_addr", fetch_addr_o, 32'h0000_0104);
        tick();                                   // WAIT
        fetch_rvalid_i = 1'b1; fetch_rdata_i = 32'h4444_0104; #1;
        chk("rel_consumed", 32'(if_valid_o), 32'h0);
        tick();                                   // REQ, addr 0x108

        // JAL to the top of the address space, then sequential wrap to 0
        fetch_rvalid_i = 1'b0; fetch_gnt_i = 1'b0;
        bju(1'b1, 2'b10, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0000_0060); #1;
        chk("wrap_ifpc", if_pc_o, 32'h0000_0104);
        chk("wrap_redir_req", 32'(fetch_req_o), 32'h0);
        tick();
        bju(1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
        fetch_gnt_i = 1'b1; #1;
        chk("wrap_flushed", 32'(if_valid_o), 32'h0);
        chk("wrap_addr_top", fetch_addr_o, 32'hFFFF_FFFC);
        chk("wrap_req_top", 32'(fetch_req_o), 32'h1);
        tick();                                   // WAIT
        fetch_rvalid_i = 1'b1; fetch_rdata_i = 32'h5555_FFFC;
        tick();                                   // REQ
        fetch_rvalid_i = 1'b0; #1;
        chk("wrap_ifpc_top", if_pc_o, 32'hFFFF_FFFC);
        chk("wrap_addr0", fetch_addr_o, 32'h0);
        chk("wrap_req0", 32'(fetch_req_o), 32'h1);
        tick();                                   // WAIT with request outstanding

        // Reset mid-flight; the late response must be ignored
        rst_i = 1'b1;
        tick();                                   // IDLE
        rst_i = 1'b0; fetch_rvalid_i = 1'b1; fetch_rdata_i = 32'h9999_9999; #1;
        chk("mid_rst_req", 32'(fetch_req_o), 32'h0);
        chk("mid_rst_ifv", 32'(if_valid_o), 32'h0);
        chk("mid_rst_exc", 32'(exc_valid_o), 32'h0);
        chk("mid_rst_tval", exc_tval_o, 32'h0);
        chk("mid_rst_instr", if_instr_o, 32'h0);
        chk("mid_rst_ifpc", if_pc_o, 32'h0);
        tick();                                   // REQ, gnt withheld
        fetch_gnt_i = 1'b0; #1;
        chk("late_ifv", 32'(if_valid_o), 32'h0);
        chk("boot_req", 32'(fetch_req_o), 32'h1);
        chk("boot_addr", fetch_addr_o, 32'h0);
        tick();
        fetch_rvalid_i = 1'b0; #1;
        chk("late_ifv2", 32'(if_valid_o), 32'h0);
        chk("boot_req2", 32'(fetch_req_o), 32'h1);
        chk("boot_addr2", fetch_addr_o, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
